// File: rtl/lsu_if.sv
// -----------------------------------------------------------------------------
// lsu_if : data-bus bundle between the load/store unit and the memory side.
//
// Signals
//   bus_req     master -> slave  request, held until granted
//   bus_we      master -> slave  write enable
//   bus_addr    master -> slave  word address (low two bits always zero)
//   bus_wmask   master -> slave  byte-lane write strobes
//   bus_wdata   master -> slave  lane-shifted store data
//   bus_gnt     slave  -> master request accepted this cycle
//   bus_rvalid  slave  -> master read data valid
//   bus_rdata   slave  -> master read data word
//
// Modports: master (the LSU) and slave (memory / interconnect).
// -----------------------------------------------------------------------------
interface lsu_if #(
    parameter int ADDR_W = 32
);
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_wmask;
    logic [31:0]       bus_wdata;
    logic              bus_gnt;
    logic              bus_rvalid;
    logic [31:0]       bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wmask, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wmask, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu : execute-stage load/store unit, one outstanding data-bus access.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   req_valid/ready request handshake from execute (ready only while idle)
//   req_we          1 = store, 0 = load
//   req_funct3      RV32I width/sign code (B, H, W, BU, HU)
//   req_addr        effective address from the ALU
//   req_wdata       store data (rs2), LSB-justified
//   req_rd          destination register, echoed on the response
//   bus             lsu_if master: req/gnt/rvalid data bus
//   rsp_valid       one-cycle completion pulse
//   rsp_rd          echoed destination register
//   rsp_rdata       extended load data, zero for stores and faults
//   rsp_fault       00 ok, 01 misaligned, 10 illegal funct3
// -----------------------------------------------------------------------------
module lsu #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    lsu_if.master             bus,
    output logic              rsp_valid,
    output logic [4:0]        rsp_rd,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_fault
);

    typedef enum logic [1:0] {IDLE, BUS, WAITR, RESP} state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        off_q, off_d;
    logic [4:0]        rd_q, rd_d;
    logic [1:0]        fault_q, fault_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [3:0]        bus_wmask_q, bus_wmask_d;
    logic [31:0]       bus_wdata_q, bus_wdata_d;

    logic        illegal, misaligned;
    logic [3:0]  storeMask;
    logic [31:0] storeData;
    logic [7:0]  loadByte;
    logic [15:0] loadHalf;
    logic [31:0] loadData;

    // Request decode: legality, alignment and store lane placement are all
    // derived from the raw request so they can be registered on the accept edge.
    always_comb begin
        illegal    = req_we ? (req_funct3[2] || (req_funct3[1:0] == 2'b11))
                            : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
        misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        storeMask  = 4'b1111;
        storeData  = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                storeMask = 4'b0001 << req_addr[1:0];
                storeData = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                storeMask = 4'b0011 << req_addr[1:0];
                storeData = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Load extraction uses the latched byte offset and width; the upper funct3
    // bit selects zero- versus sign-extension.
    always_comb begin
        loadByte = bus.bus_rdata[{off_q, 3'b000} +: 8];
        loadHalf = off_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
        case (funct3_q)
            3'b000:  loadData = {{24{loadByte[7]}}, loadByte};
            3'b001:  loadData = {{16{loadHalf[15]}}, loadHalf};
            3'b100:  loadData = {24'd0, loadByte};
            3'b101:  loadData = {16'd0, loadHalf};
            default: loadData = bus.bus_rdata;
        endcase
    end

    // Next-state logic. Faulting requests skip the bus entirely and go straight
    // to the response; rvalid is only honoured while waiting for read data.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        rd_d        = rd_q;
        fault_d     = fault_q;
        rdata_d     = rdata_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wmask_d = bus_wmask_q;
        bus_wdata_d = bus_wdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    off_d    = req_addr[1:0];
                    rd_d     = req_rd;
                    rdata_d  = 32'd0;
                    fault_d  = 2'b00;
                    if (illegal) begin
                        fault_d = 2'b10;
                        state_d = RESP;
                    end else if (misaligned) begin
                        fault_d = 2'b01;
                        state_d = RESP;
                    end else begin
                        bus_req_d   = 1'b1;
                        bus_we_d    = req_we;
                        bus_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
                        bus_wmask_d = req_we ? storeMask : 4'b0000;
                        bus_wdata_d = req_we ? storeData : 32'd0;
                        state_d     = BUS;
                    end
                end
            end
            BUS: begin
                if (bus.bus_gnt) begin
                    bus_req_d = 1'b0;
                    state_d   = we_q ? RESP : WAITR;
                end
            end
            WAITR: begin
                if (bus.bus_rvalid) begin
                    rdata_d = loadData;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            rd_q        <= 5'd0;
            fault_q     <= 2'b00;
            rdata_q     <= 32'd0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wmask_q <= 4'b0000;
            bus_wdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            rd_q        <= rd_d;
            fault_q     <= fault_d;
            rdata_q     <= rdata_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wmask_q <= bus_wmask_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    assign req_ready     = (state_q == IDLE);
    assign rsp_valid     = (state_q == RESP);
    assign rsp_rd        = rd_q;
    assign rsp_rdata     = rdata_q;
    assign rsp_fault     = fault_q;
    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wmask = bus_wmask_q;
    assign bus.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// -----------------------------------------------------------------------------
// tb_lsu : scoreboard bench for the load/store unit.
// A driver issues requests and pushes expected bus transfers and responses
// computed by a width/offset reference model; a bus responder and a response
// monitor pop and compare independently.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        rsp_valid;
    logic [4:0]  rsp_rd;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_fault;

    lsu_if #(.ADDR_W(32)) busIf ();

    lsu #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .bus        (busIf),
        .rsp_valid  (rsp_valid),
        .rsp_rd     (rsp_rd),
        .rsp_rdata  (rsp_rdata),
        .rsp_fault  (rsp_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic [1:0]  fault;
        int          lat;
    } rspExp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] wdata;
        int          gntDelay;
        int          rvDelay;
        logic [31:0] rdata;
    } busExp_t;

    rspExp_t rspQ[$];
    busExp_t busQ[$];
    int      accQ[$];

    int checks = 0;
    int passes = 0;
    int cycle = 0;
    int lastRspCycle = -1;
    bit autoBus = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic failNote(input string name);
        checks++;
        $display("[TB] FAIL %s: event did not occur as required", name);
    endtask

    // Reference model: width from funct3, legality lists, natural alignment,
    // byte lanes by offset arithmetic and extension by masking.
    function automatic void refModel(input logic we, input logic [2:0] f3,
                                     input logic [31:0] addr, input logic [31:0] wdata,
                                     input logic [31:0] rdata,
                                     output logic [1:0] fault, output logic [31:0] result,
                                     output logic [3:0] mask, output logic [31:0] laneData);
        int size;
        int off;
        bit legal;
        logic [31:0] raw;
        logic [31:0] low;
        case (f3[1:0])
            2'd0:    size = 1;
            2'd1:    size = 2;
            2'd2:    size = 4;
            default: size = 0;
        endcase
        legal    = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        off      = int'(addr % 4);
        fault    = 2'b00;
        result   = 32'd0;
        mask     = 4'b0000;
        laneData = 32'd0;
        if (!legal) fault = 2'b10;
        else if ((addr % size) != 0) fault = 2'b01;
        else if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (i >= off && i < off + size) mask[i] = 1'b1;
                laneData[8*i +: 8] = wdata[8*(i % size) +: 8];
            end
        end else begin
            raw = rdata >> (8 * off);
            if (size < 4) begin
                low = (32'd1 << (8 * size)) - 32'd1;
                raw = raw & low;
                if (!f3[2] && raw[8*size-1]) raw = raw | ~low;
            end
            result = raw;
        end
    endfunction

    // Drive one request (holding whatever req_valid level the caller left)
    // and return the cycle stamp of its accept edge.
    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [4:0] rd,
                                 input int gd, input int rvd, input logic [31:0] rdata,
                                 output int acc);
        rspExp_t e;
        busExp_t b;
        logic [3:0]  mask;
        logic [31:0] lane;
        int waited;
        refModel(we, f3, addr, wdata, rdata, e.fault, e.rdata, mask, lane);
        e.rd  = rd;
        e.lat = (e.fault != 2'b00) ? 2 : (we ? 3 + gd : 4 + gd + rvd);
        rspQ.push_back(e);
        if (e.fault == 2'b00) begin
            b.we = we; b.addr = {addr[31:2], 2'b00}; b.mask = mask; b.wdata = lane;
            b.gntDelay = gd; b.rvDelay = rvd; b.rdata = rdata;
            busQ.push_back(b);
        end
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr;
        req_wdata = wdata; req_rd = rd;
        waited = 0;
        while (!req_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            failNote("accept_timeout");
            req_valid = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc = cycle;
        accQ.push_back(acc);
        @(negedge clk);
        checkOutput("ready_low_after_accept", {31'd0, req_ready}, 32'd0);
    endtask

    task automatic waitDrain();
        int n = 0;
        while (rspQ.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (rspQ.size() != 0) failNote("drain_timeout");
        rspQ.delete(); busQ.delete(); accQ.delete();
        @(negedge clk);
    endtask

    // Response monitor: pops the scoreboard on each completion pulse.
    always @(negedge clk) begin : monitor
        rspExp_t e;
        int a;
        if (rst_n && rsp_valid) begin
            if (rspQ.size() == 0) failNote("unexpected_rsp");
            else begin
                e = rspQ.pop_front();
                a = (accQ.size() != 0) ? accQ.pop_front() : -1000;
                checkOutput("rsp_rd", {27'd0, rsp_rd}, {27'd0, e.rd});
                checkOutput("rsp_rdata", rsp_rdata, e.rdata);
                checkOutput("rsp_fault", {30'd0, rsp_fault}, {30'd0, e.fault});
                checkOutput("rsp_latency", cycle - a + 2, e.lat);
                checkOutput("ready_low_in_resp", {31'd0, req_ready}, 32'd0);
            end
            lastRspCycle = cycle;
        end
    end

    // Bus responder: grants after the scripted delay, checks the registered
    // bus fields, and returns read data after the scripted rvalid delay.
    always @(negedge clk) begin : responder
        busExp_t cur;
        int phase;
        int waitCnt;
        if (!autoBus) phase = 0;
        else begin
            busIf.bus_gnt    = 1'b0;
            busIf.bus_rvalid = 1'b0;
            busIf.bus_rdata  = $urandom;
            if (phase == 2) begin
                checkOutput("bus_req_low_waitr", {31'd0, busIf.bus_req}, 32'd0);
                if (waitCnt == 0) begin
                    busIf.bus_rvalid = 1'b1;
                    busIf.bus_rdata  = cur.rdata;
                    phase = 0;
                end else waitCnt--;
            end else begin
                if (phase == 0 && busIf.bus_req) begin
                    if (busQ.size() == 0) begin
                        failNote("unexpected_bus_req");
                        busIf.bus_gnt = 1'b1;
                    end else begin
                        cur = busQ.pop_front();
                        waitCnt = cur.gntDelay;
                        phase = 1;
                    end
                end
                if (phase == 1) begin
                    checkOutput("bus_req_held", {31'd0, busIf.bus_req}, 32'd1);
                    if (waitCnt == 0) begin
                        checkOutput("bus_addr", busIf.bus_addr, cur.addr);
                        checkOutput("bus_we", {31'd0, busIf.bus_we}, {31'd0, cur.we});
                        if (cur.we) begin
                            checkOutput("bus_wmask", {28'd0, busIf.bus_wmask}, {28'd0, cur.mask});
                            checkOutput("bus_wdata", busIf.bus_wdata, cur.wdata);
                        end
                        busIf.bus_gnt = 1'b1;
                        if ($urandom_range(0, 3) == 0) busIf.bus_rvalid = 1'b1;
                        phase = cur.we ? 0 : 2;
                        waitCnt = cur.rvDelay;
                    end else waitCnt--;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int acc;
        int acc2;
        int firstRsp;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
        busIf.bus_gnt = 1'b0; busIf.bus_rvalid = 1'b0; busIf.bus_rdata = 32'd0;
        repeat (2) @(negedge clk);
        checkOutput("reset_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("reset_bus_req", {31'd0, busIf.bus_req}, 32'd0);
        checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("reset_bus_wmask", {28'd0, busIf.bus_wmask}, 32'd0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        autoBus = 1'b1;

        $display("[TB] directed accesses");
        applyStimulus(1'b0, 3'b000, 32'h0000_1003, 32'd0, 5'd7, 0, 0, 32'h80FF_1234, acc);
        req_valid = 1'b0; waitDrain();
        applyStimulus(1'b1, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 5'd3, 2, 0, 32'd0, acc);
        req_valid = 1'b0; waitDrain();
        applyStimulus(1'b0, 3'b010, 32'h0000_0006, 32'd0, 5'd9, 0, 0, 32'd0, acc);
        req_valid = 1'b0; waitDrain();
        applyStimulus(1'b0, 3'b011, 32'h0000_0000, 32'd0, 5'd10, 0, 0, 32'd0, acc);
        req_valid = 1'b0; waitDrain();
        applyStimulus(1'b0, 3'b101, 32'h0000_0002, 32'd0, 5'd11, 1, 2, 32'h8001_0000, acc);
        req_valid = 1'b0; waitDrain();
        applyStimulus(1'b0, 3'b001, 32'h0000_0002, 32'd0, 5'd12, 0, 1, 32'h8001_0000, acc);
        req_valid = 1'b0; waitDrain();

        $display("[TB] back-to-back requests");
        applyStimulus(1'b1, 3'b000, 32'h0000_0101, 32'h0000_00A5, 5'd13, 1, 0, 32'd0, acc);
        applyStimulus(1'b0, 3'b010, 32'h0000_0200, 32'd0, 5'd14, 0, 0, 32'h1234_5678, acc2);
        firstRsp = lastRspCycle;
        req_valid = 1'b0;
        checkOutput("b2b_accept_after_pulse", acc2, firstRsp + 2);
        waitDrain();

        $display("[TB] randomized accesses");
        for (int i = 0; i < 80; i++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
            else if (we) f3 = 3'($urandom_range(0, 2));
            else begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
                endcase
            end
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'b01) addr[0] = 1'b0;
                if (f3[1:0] == 2'b10) addr[1:0] = 2'b00;
            end
            applyStimulus(we, f3, addr, $urandom, 5'($urandom_range(0, 31)),
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom, acc);
            if ($urandom_range(0, 1) == 1) begin
                req_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        req_valid = 1'b0;
        waitDrain();

        $display("[TB] reset during bus phase");
        autoBus = 1'b0;
        busIf.bus_gnt = 1'b0; busIf.bus_rvalid = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40;
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("bus_req_in_bus", {31'd0, busIf.bus_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("bus_req_drop_on_reset", {31'd0, busIf.bus_req}, 32'd0);
        checkOutput("ready_on_reset", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] reset during read wait");
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h80;
        @(negedge clk);
        req_valid = 1'b0;
        busIf.bus_gnt = 1'b1;
        @(negedge clk);
        busIf.bus_gnt = 1'b0;
        checkOutput("bus_req_low_after_gnt", {31'd0, busIf.bus_req}, 32'd0);
        checkOutput("ready_low_in_waitr", {31'd0, req_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("waitr_reset_bus_req", {31'd0, busIf.bus_req}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_release", {31'd0, req_ready}, 32'd1);
        busIf.bus_rvalid = 1'b1; busIf.bus_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        busIf.bus_rvalid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("no_rsp_after_late_rvalid", {31'd0, rsp_valid}, 32'd0);
        end

        $display("[TB] access after reset");
        autoBus = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, 3'b100, 32'h0000_0301, 32'd0, 5'd21, 1, 1, 32'h0000_9A00, acc);
        req_valid = 1'b0;
        waitDrain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
